alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//  Parametrised, registered ALU control with multi-cycle sequencing. Sits in EX: decodes {funct7,funct3}/ALUOp
//  into an ALU op code and, for multi-cycle ops (MUL, optional DIV/REM), runs a latency counter that stalls the
//  pipeline until done. Illegal encodings produce an explicit NOP code and an illegal flag.
// PARAMETERS
//  CTRL_W   4   width of ALUCtrl_o; must be >= 4
//  MUL_LAT  4   cycles a MUL occupies the ALU; must be >= 1
//  DIV_LAT  33  cycles a DIV/REM occupies the ALU; must be >= 1; used only with ALU_CTRL_DIV_EN
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       reset, asynchronous, active-low
//  valid_i      in   1       decode request present
//  ready_o      out  1       block can accept; a transfer happens when valid_i & ready_o & ~flush_i
//  flush_i      in   1       abort current/incoming op
//  funct_i      in   10      {funct7[9:3], funct3[2:0]}
//  ALUOp_i      in   2       00 R-type/ld/st, 01 I-type arith, 10 branch compare, 11 reserved
//  ALUCtrl_o    out  CTRL_W  registered ALU op code, zero-extended to CTRL_W
//  ctrl_valid_o out  1       one-cycle pulse: ALUCtrl_o is newly valid
//  illegal_o    out  1       coincident with ctrl_valid_o: encoding was illegal
//  stall_o      out  1       multi-cycle op in progress; hold upstream stages
//  done_o       out  1       one-cycle pulse: last cycle of a multi-cycle op
// BEHAVIOUR
//  Codes: AND 0, XOR 1, SLL 2, ADD 3, SUB 4, MUL 5, ADDI 6, SRAI 7, DIV 8, REM 9, NOP F.
//  Decode:
//   ALUOp 00:
//    f3=000: f7=0000000 ADD, 0100000 SUB, 0000001 MUL
//    f3=100: f7=0000000 XOR
//    f3=111: f7=0000000 AND
//    f3=001: f7=0000000 SLL
//    f3=010: ADD (lw/sw); f7 ignored because it carries immediate bits
//   ALUOp 01:
//    f3=000: ADDI (f7 ignored)
//    f3=101: f7=0100000 SRAI
//   ALUOp 10: SUB
//   Any other combination, including ALUOp 11: NOP (F) with illegal_o=1.
//  Single-cycle decode is fully combinational: every path assigns a value, so no latches are inferred.
//  Reset (rst_i=0, takes effect immediately, including mid-op):
//   state=IDLE, cnt=0, ALUCtrl_o=F, ctrl_valid_o=0, illegal_o=0
//   ready_o=1, stall_o=0, done_o=0
//  FSM (2 states):
//   IDLE: ready_o=1.
//    Transfer at edge T -> in cycle T+1 ALUCtrl_o=code, ctrl_valid_o=1, illegal_o as decoded.
//    If code is MUL (or DIV/REM) -> BUSY with cnt=LAT-1. Otherwise stay IDLE (back-to-back issue allowed).
//   BUSY: ready_o=0, stall_o=1, ALUCtrl_o held.
//    cnt decrements every cycle.
//    done_o = (cnt==0) combinationally; on that edge -> IDLE.
//    A MUL accepted at edge T is therefore BUSY in cycles T+1..T+MUL_LAT, has done_o in cycle T+MUL_LAT,
//    and ready_o returns in cycle T+MUL_LAT+1.
//  ctrl_valid_o and illegal_o are single-cycle pulses; ALUCtrl_o holds its last value until the next transfer.
//  flush_i=1 at an edge, in any state:
//   next state IDLE, cnt=0, ALUCtrl_o=F, ctrl_valid_o=0, illegal_o=0
//   no done_o is produced for the aborted op
//   flush_i beats a simultaneous valid_i: that request is not accepted
//  valid_i while BUSY is ignored; the requester holds it until ready_o=1.
//  cnt width is $clog2(max latency)+1 and must not wrap; LAT=1 gives one BUSY cycle, with done_o high in it.
// CONFIGURATION
//  ALU_CTRL_DIV_EN defined:
//   ALUOp 00 with f7=0000001: f3=100 -> DIV (8), f3=110 -> REM (9)
//   both are multi-cycle with DIV_LAT
//  ALU_CTRL_DIV_EN undefined:
//   those encodings decode as illegal (F, illegal_o=1), with no BUSY entry
//   DIV_LAT is unused
// TESTING
//  Reset: rst_i=0 mid-BUSY (MUL, cnt=2) -> immediately ALUCtrl_o=F, ready_o=1, stall_o=0, done_o=0.
//  Single-cycle stream, ALUOp=00:
//   valid_i on 3 consecutive cycles with funct_i={0000000,000}, {0100000,000}, {0000000,111}
//   -> ALUCtrl_o = 3, 4, 0 on the 3 following cycles, ctrl_valid_o=1 each, ready_o never drops.
//  MUL, MUL_LAT=4: accept at edge T -> ALUCtrl_o=5, stall_o=1 in T+1..T+4, done_o=1 only in T+4, ready_o=1 at T+5;
//   valid_i held during BUSY is accepted at T+5.
//  Illegal: ALUOp=11, or ALUOp=00 with funct_i={0000001,100} without DIV_EN -> ALUCtrl_o=F, illegal_o=1 for 1 cycle.
//  Flush: flush_i=1 in cycle T+2 of a MUL -> IDLE next cycle, ALUCtrl_o=F, no done_o;
//   flush_i with valid_i in IDLE -> nothing accepted.
//  DIV_EN, DIV_LAT=33: funct_i={0000001,110} -> ALUCtrl_o=9, stall_o high for 33 cycles, done_o on the 33rd.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: decodes {funct7,funct3}/ALUOp into a registered op code and sequences multi-cycle ops.
// Optional DIV/REM support is enabled by defining ALU_CTRL_DIV_EN.
module alu_ctrl_seq #(
   parameter int CTRL_W  = 4,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 33
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              flush_i,
   input  logic [9:0]        funct_i,
   input  logic [1:0]        ALUOp_i,
   output logic [CTRL_W-1:0] ALUCtrl_o,
   output logic              ctrl_valid_o,
   output logic              illegal_o,
   output logic              stall_o,
   output logic              done_o,
   output logic              state_dbg_o
);

   // Handshake: a request transfers on a rising edge where valid_i & ready_o & ~flush_i;
   // the requester keeps valid_i and its fields stable until then.

   localparam logic [3:0] OP_AND  = 4'h0;
   localparam logic [3:0] OP_XOR  = 4'h1;
   localparam logic [3:0] OP_SLL  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_MUL  = 4'h5;
   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_SRAI = 4'h7;
   localparam logic [3:0] OP_DIV  = 4'h8;
   localparam logic [3:0] OP_REM  = 4'h9;
   localparam logic [3:0] OP_NOP  = 4'hF;

`ifdef ALU_CTRL_DIV_EN
   localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
`else
   localparam int MAX_LAT = MUL_LAT + 0 * DIV_LAT;
`endif
   localparam int CNT_W = $clog2(MAX_LAT) + 1;

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
`ifdef ALU_CTRL_DIV_EN
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
`endif

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              cvalid_q, cvalid_d;
   logic              illegal_q, illegal_d;

   logic [6:0]        f7;
   logic [2:0]        f3;
   logic [3:0]        dec_code;
   logic              dec_ill;
   logic              dec_multi;
   logic [CNT_W-1:0]  dec_cnt;
   logic              accept;

   assign f7 = funct_i[9:3];
   assign f3 = funct_i[2:0];

   // Combinational decode; every path leaves a complete result.
   always_comb begin
      dec_code  = OP_NOP;
      dec_ill   = 1'b1;
      dec_multi = 1'b0;
      dec_cnt   = '0;
      case (ALUOp_i)
         2'b00: begin
            case (f3)
               3'b000: begin
                  if (f7 == 7'b0000000) begin
                     dec_code = OP_ADD;
                     dec_ill  = 1'b0;
                  end else if (f7 == 7'b0100000) begin
                     dec_code = OP_SUB;
                     dec_ill  = 1'b0;
                  end else if (f7 == 7'b0000001) begin
                     dec_code  = OP_MUL;
                     dec_ill   = 1'b0;
                     dec_multi = 1'b1;
                     dec_cnt   = MUL_CNT;
                  end
               end
               3'b100: begin
                  if (f7 == 7'b0000000) begin
                     dec_code = OP_XOR;
                     dec_ill  = 1'b0;
`ifdef ALU_CTRL_DIV_EN
                  end else if (f7 == 7'b0000001) begin
                     dec_code  = OP_DIV;
                     dec_ill   = 1'b0;
                     dec_multi = 1'b1;
                     dec_cnt   = DIV_CNT;
`endif
                  end
               end
`ifdef ALU_CTRL_DIV_EN
               3'b110: begin
                  if (f7 == 7'b0000001) begin
                     dec_code  = OP_REM;
                     dec_ill   = 1'b0;
                     dec_multi = 1'b1;
                     dec_cnt   = DIV_CNT;
                  end
               end
`endif
               3'b111: begin
                  if (f7 == 7'b0000000) begin
                     dec_code = OP_AND;
                     dec_ill  = 1'b0;
                  end
               end
               3'b001: begin
                  if (f7 == 7'b0000000) begin
                     dec_code = OP_SLL;
                     dec_ill  = 1'b0;
                  end
               end
               // Loads/stores: f7 carries immediate bits and is ignored.
               3'b010: begin
                  dec_code = OP_ADD;
                  dec_ill  = 1'b0;
               end
               default: ;
            endcase
         end
         2'b01: begin
            if (f3 == 3'b000) begin
               dec_code = OP_ADDI;
               dec_ill  = 1'b0;
            end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
               dec_code = OP_SRAI;
               dec_ill  = 1'b0;
            end
         end
         2'b10: begin
            dec_code = OP_SUB;
            dec_ill  = 1'b0;
         end
         default: ;
      endcase
   end

   assign accept = valid_i && (state_q == S_IDLE) && !flush_i;

   // Next-state: flush dominates, then a new transfer, then the BUSY countdown.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl_d    = ctrl_q;
      cvalid_d  = 1'b0;
      illegal_d = 1'b0;
      if (flush_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         ctrl_d  = CTRL_W'(OP_NOP);
      end else if (accept) begin
         ctrl_d    = CTRL_W'(dec_code);
         cvalid_d  = 1'b1;
         illegal_d = dec_ill;
         if (dec_multi) begin
            state_d = S_BUSY;
            cnt_d   = dec_cnt;
         end
      end else if (state_q == S_BUSY) begin
         if (cnt_q == '0) begin
            state_d = S_IDLE;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ctrl_q    <= CTRL_W'(OP_NOP);
         cvalid_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ctrl_q    <= ctrl_d;
         cvalid_q  <= cvalid_d;
         illegal_q <= illegal_d;
      end
   end

   assign ready_o      = (state_q == S_IDLE);
   assign stall_o      = (state_q == S_BUSY);
   assign done_o       = (state_q == S_BUSY) && (cnt_q == '0);
   assign ALUCtrl_o    = ctrl_q;
   assign ctrl_valid_o = cvalid_q;
   assign illegal_o    = illegal_q;
   assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed vectors against a cycle-level reference model plus literal checks.
// Works in both builds; DIV/REM vectors are selected by ALU_CTRL_DIV_EN.
module tb_alu_ctrl_seq;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 33;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid, flush;
   logic [9:0] funct;
   logic [1:0] aluop;
   logic       ready, cvalid, illegal, stall, done, state_dbg;
   logic [3:0] ctrl;
   logic       cmp_en = 1'b0;

   always #5 clk = ~clk;

   alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(ready), .flush_i(flush),
      .funct_i(funct), .ALUOp_i(aluop), .ALUCtrl_o(ctrl), .ctrl_valid_o(cvalid),
      .illegal_o(illegal), .stall_o(stall), .done_o(done), .state_dbg_o(state_dbg)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [3:0] code;
      logic       ill;
      int         lat;
   } dec_t;

   function automatic dec_t ref_decode(input logic [1:0] op, input logic [9:0] fn);
      dec_t       r;
      logic [6:0] f7;
      logic [2:0] f3;
      f7 = fn[9:3];
      f3 = fn[2:0];
      r.code = 4'hF;
      r.ill  = 1'b1;
      r.lat  = 0;
      if (op == 2'b10) begin
         r.code = 4'd4; r.ill = 1'b0;
      end else if (op == 2'b01) begin
         if (f3 == 3'd0) begin r.code = 4'd6; r.ill = 1'b0; end
         else if (f3 == 3'd5 && f7 == 7'b0100000) begin r.code = 4'd7; r.ill = 1'b0; end
      end else if (op == 2'b00) begin
         if (f3 == 3'b010) begin r.code = 4'd3; r.ill = 1'b0; end
         else if (f7 == 7'd0 && f3 == 3'd0) begin r.code = 4'd3; r.ill = 1'b0; end
         else if (f7 == 7'd0 && f3 == 3'd4) begin r.code = 4'd1; r.ill = 1'b0; end
         else if (f7 == 7'd0 && f3 == 3'd7) begin r.code = 4'd0; r.ill = 1'b0; end
         else if (f7 == 7'd0 && f3 == 3'd1) begin r.code = 4'd2; r.ill = 1'b0; end
         else if (f7 == 7'b0100000 && f3 == 3'd0) begin r.code = 4'd4; r.ill = 1'b0; end
         else if (f7 == 7'd1 && f3 == 3'd0) begin r.code = 4'd5; r.ill = 1'b0; r.lat = MUL_LAT; end
`ifdef ALU_CTRL_DIV_EN
         else if (f7 == 7'd1 && f3 == 3'd4) begin r.code = 4'd8; r.ill = 1'b0; r.lat = DIV_LAT; end
         else if (f7 == 7'd1 && f3 == 3'd6) begin r.code = 4'd9; r.ill = 1'b0; r.lat = DIV_LAT; end
`endif
      end
      return r;
   endfunction

   dec_t       ref_now;
   int         m_left;
   logic [3:0] m_ctrl;
   logic       m_cv, m_ill;

   assign ref_now = ref_decode(aluop, funct);

   // m_left = BUSY cycles still to come, counting the current one.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0; m_ctrl <= 4'hF; m_cv <= 1'b0; m_ill <= 1'b0;
      end else if (flush) begin
         m_left <= 0; m_ctrl <= 4'hF; m_cv <= 1'b0; m_ill <= 1'b0;
      end else if (valid && m_left == 0) begin
         m_ctrl <= ref_now.code; m_cv <= 1'b1; m_ill <= ref_now.ill; m_left <= ref_now.lat;
      end else begin
         m_cv <= 1'b0; m_ill <= 1'b0;
         if (m_left > 0) m_left <= m_left - 1;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         check("cmp_ctrl",    ctrl,    m_ctrl);
         check("cmp_cvalid",  cvalid,  m_cv);
         check("cmp_illegal", illegal, m_ill);
         check("cmp_ready",   ready,   m_left == 0);
         check("cmp_stall",   stall,   m_left > 0);
         check("cmp_done",    done,    m_left == 1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [9:0] fn);
      valid = v;
      aluop = op;
      funct = fn;
   endtask

   task automatic summary();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
   endtask

   // Directed single-cycle table with hand-computed results.
   localparam int NV = 9;
   logic [1:0] v_op  [NV] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
   logic [9:0] v_fn  [NV] = '{{7'b1010101, 3'b000}, {7'b0100000, 3'b101}, {7'b0000000, 3'b101},
                              {7'b0000000, 3'b001}, {7'b1111111, 3'b010}, {7'b0000000, 3'b100},
                              {7'b1111111, 3'b111}, {7'b0100000, 3'b111}, {7'b0000001, 3'b110}};
`ifdef ALU_CTRL_DIV_EN
   logic [3:0] v_exp [NV] = '{4'd6, 4'd7, 4'hF, 4'd2, 4'd3, 4'd1, 4'd4, 4'hF, 4'd9};
   logic       v_ill [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
   logic [3:0] v_exp [NV] = '{4'd6, 4'd7, 4'hF, 4'd2, 4'd3, 4'd1, 4'd4, 4'hF, 4'hF};
   logic       v_ill [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      drive(1'b0, 2'b00, 10'd0);
      repeat (3) tick();
      check("rst_ctrl",   ctrl,   4'hF);
      check("rst_cvalid", cvalid, 1'b0);
      check("rst_ready",  ready,  1'b1);
      check("rst_stall",  stall,  1'b0);
      check("rst_done",   done,   1'b0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      tick();

      // Back-to-back single-cycle stream: ADD, SUB, AND.
      drive(1'b1, 2'b00, {7'b0000000, 3'b000});
      tick();
      check("stream_add", ctrl, 4'd3);
      check("stream_cv0", cvalid, 1'b1);
      check("stream_rdy0", ready, 1'b1);
      drive(1'b1, 2'b00, {7'b0100000, 3'b000});
      tick();
      check("stream_sub", ctrl, 4'd4);
      check("stream_rdy1", ready, 1'b1);
      drive(1'b1, 2'b00, {7'b0000000, 3'b111});
      tick();
      check("stream_and", ctrl, 4'd0);
      check("stream_cv2", cvalid, 1'b1);
      drive(1'b0, 2'b00, 10'd0);
      tick();
      check("stream_cv_off", cvalid, 1'b0);
      check("stream_hold", ctrl, 4'd0);

      // MUL with a request held during BUSY.
      drive(1'b1, 2'b00, {7'b0000001, 3'b000});
      for (int k = 1; k <= MUL_LAT; k++) begin
         tick();
         check("mul_ctrl",  ctrl,  4'd5);
         check("mul_stall", stall, 1'b1);
         check("mul_ready", ready, 1'b0);
         check("mul_done",  done,  k == MUL_LAT);
         if (k == 1) drive(1'b1, 2'b00, {7'b0000000, 3'b100});
      end
      tick();
      check("mul_ready_back", ready, 1'b1);
      check("mul_stall_off",  stall, 1'b0);
      tick();
      check("held_xor", ctrl, 4'd1);
      check("held_cv",  cvalid, 1'b1);
      drive(1'b0, 2'b00, 10'd0);

      // Illegal encodings.
      drive(1'b1, 2'b11, 10'd0);
      tick();
      check("ill_op11_ctrl", ctrl, 4'hF);
      check("ill_op11_flag", illegal, 1'b1);
      drive(1'b0, 2'b00, 10'd0);
      tick();
      check("ill_pulse_end", illegal, 1'b0);
      drive(1'b1, 2'b00, {7'b0000001, 3'b100});
      tick();
      drive(1'b0, 2'b00, 10'd0);
`ifdef ALU_CTRL_DIV_EN
      check("div_ctrl",  ctrl,  4'd8);
      check("div_stall", stall, 1'b1);
      repeat (DIV_LAT) tick();
      check("div_ready", ready, 1'b1);
`else
      check("nodiv_ctrl",  ctrl,    4'hF);
      check("nodiv_ill",   illegal, 1'b1);
      check("nodiv_stall", stall,   1'b0);
      tick();
`endif

      // Flush in cycle T+2 of a MUL.
      drive(1'b1, 2'b00, {7'b0000001, 3'b000});
      tick();
      drive(1'b0, 2'b00, 10'd0);
      tick();
      check("flush_pre_stall", stall, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_ctrl",  ctrl,  4'hF);
      check("flush_ready", ready, 1'b1);
      check("flush_stall", stall, 1'b0);
      check("flush_done",  done,  1'b0);
      tick();
      check("flush_no_done", done, 1'b0);

      // Flush beats a simultaneous request in IDLE.
      drive(1'b1, 2'b00, {7'b0000000, 3'b000});
      tick();
      check("pre_flush_add", ctrl, 4'd3);
      drive(1'b1, 2'b00, {7'b0000000, 3'b100});
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 2'b00, 10'd0);
      check("flush_idle_cv",   cvalid, 1'b0);
      check("flush_idle_ctrl", ctrl,   4'hF);

      // Asynchronous reset in the middle of a MUL (cnt=2).
      drive(1'b1, 2'b00, {7'b0000001, 3'b000});
      tick();
      drive(1'b0, 2'b00, 10'd0);
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      check("amid_ctrl",  ctrl,  4'hF);
      check("amid_ready", ready, 1'b1);
      check("amid_stall", stall, 1'b0);
      check("amid_done",  done,  1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // Table of single-cycle encodings issued back to back.
      for (int i = 0; i < NV; i++) begin
         drive(1'b1, v_op[i], v_fn[i]);
         tick();
         check($sformatf("vec%0d_ctrl", i), ctrl, v_exp[i]);
         check($sformatf("vec%0d_ill", i), illegal, v_ill[i]);
      end
      drive(1'b0, 2'b00, 10'd0);
`ifdef ALU_CTRL_DIV_EN
      repeat (DIV_LAT) tick();
`endif
      tick();

      // Two MULs back to back from a continuously held request.
      drive(1'b1, 2'b00, {7'b0000001, 3'b000});
      repeat (MUL_LAT + 2) tick();
      drive(1'b0, 2'b00, 10'd0);
      repeat (MUL_LAT + 2) tick();

`ifdef ALU_CTRL_DIV_EN
      // REM runs for DIV_LAT cycles.
      drive(1'b1, 2'b00, {7'b0000001, 3'b110});
      for (int k = 1; k <= DIV_LAT; k++) begin
         tick();
         if (k == 1) drive(1'b0, 2'b00, 10'd0);
         check("rem_ctrl",  ctrl,  4'd9);
         check("rem_stall", stall, 1'b1);
         check("rem_done",  done,  k == DIV_LAT);
      end
      tick();
      check("rem_ready", ready, 1'b1);
`endif

      repeat (2) tick();
      summary();
      $finish;
   end

   initial begin
      #200000;
      n_miss++;
      $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
      summary();
      $fatal(1, "watchdog expired");
   end

endmodule
